// File: rtl/bcd_updown_counter.sv
// Packed-BCD up/down counter with enable, parallel load, synchronous clear and
// wrap/saturate limit handling. All outputs are registered.
module bcd_updown_counter #(
  parameter int                  DIGITS   = 5,
  parameter bit                  SATURATE = 1'b0,
  parameter logic [4*DIGITS-1:0] MAX_BCD  = {DIGITS{4'h9}}
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_value_i,
  input  logic                en_i,
  input  logic                up_i,
  output logic [4*DIGITS-1:0] value_o,
  output logic                wrap_o,
  output logic                at_max_o,
  output logic                at_zero_o,
  output logic                load_err_o
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0] value_q, value_d;
  logic         wrap_q, wrap_d;
  logic         load_err_q, load_err_d;
  logic         at_max_q, at_max_d;
  logic         at_zero_q, at_zero_d;

  logic [W-1:0] inc_v, dec_v, sane_v;
  logic         digit_fixed, over_max;

  // Ripple increment: digits at 9 roll to 0 until the first non-9 digit.
  always_comb begin : inc_chain
    logic carry;
    carry = 1'b1;
    inc_v = value_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value_q[4*i +: 4] == 4'd9) begin
          inc_v[4*i +: 4] = 4'd0;
        end else begin
          inc_v[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

  always_comb begin : dec_chain
    logic borrow;
    borrow = 1'b1;
    dec_v  = value_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (value_q[4*i +: 4] == 4'd0) begin
          dec_v[4*i +: 4] = 4'd9;
        end else begin
          dec_v[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  always_comb begin : load_fix
    sane_v      = load_value_i;
    digit_fixed = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value_i[4*i +: 4] > 4'd9) begin
        sane_v[4*i +: 4] = 4'd9;
        digit_fixed      = 1'b1;
      end
    end
  end

  // With every digit <= 9, BCD ordering equals plain unsigned ordering.
  assign over_max = (sane_v > MAX_BCD);

  always_comb begin : next_state
    value_d    = value_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (clear_i) begin
      value_d = '0;
    end else if (load_i) begin
      value_d    = over_max ? MAX_BCD : sane_v;
      load_err_d = digit_fixed | over_max;
    end else if (en_i) begin
      if (up_i) begin
        if (value_q == MAX_BCD) begin
          wrap_d  = 1'b1;
          value_d = SATURATE ? value_q : '0;
        end else begin
          value_d = inc_v;
        end
      end else begin
        if (value_q == '0) begin
          wrap_d  = 1'b1;
          value_d = SATURATE ? value_q : MAX_BCD;
        end else begin
          value_d = dec_v;
        end
      end
    end
    at_max_d  = (value_d == MAX_BCD);
    at_zero_d = (value_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      value_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      at_max_q   <= 1'b0;
      at_zero_q  <= 1'b1;
    end else begin
      value_q    <= value_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      at_max_q   <= at_max_d;
      at_zero_q  <= at_zero_d;
    end
  end

  assign value_o    = value_q;
  assign wrap_o     = wrap_q;
  assign load_err_o = load_err_q;
  assign at_max_o   = at_max_q;
  assign at_zero_o  = at_zero_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: wrap, saturate, reduced-limit and
// single-digit variants share one set of stimulus inputs.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        nReset;
  logic        clr, ld, en, up;
  logic [19:0] lv;

  logic [19:0] v0, v1, v2;
  logic [3:0]  v3;
  logic        w0, w1, w2, w3;
  logic        mx0, mx1, mx2, mx3;
  logic        z0, z1, z2, z3;
  logic        le0, le1, le2, le3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_updown_counter dut0 (
    .clk(clk), .nReset(nReset), .clear_i(clr), .load_i(ld), .load_value_i(lv),
    .en_i(en), .up_i(up), .value_o(v0), .wrap_o(w0), .at_max_o(mx0),
    .at_zero_o(z0), .load_err_o(le0));

  bcd_updown_counter #(.SATURATE(1'b1)) dut1 (
    .clk(clk), .nReset(nReset), .clear_i(clr), .load_i(ld), .load_value_i(lv),
    .en_i(en), .up_i(up), .value_o(v1), .wrap_o(w1), .at_max_o(mx1),
    .at_zero_o(z1), .load_err_o(le1));

  bcd_updown_counter #(.MAX_BCD(20'h00059)) dut2 (
    .clk(clk), .nReset(nReset), .clear_i(clr), .load_i(ld), .load_value_i(lv),
    .en_i(en), .up_i(up), .value_o(v2), .wrap_o(w2), .at_max_o(mx2),
    .at_zero_o(z2), .load_err_o(le2));

  bcd_updown_counter #(.DIGITS(1)) dut3 (
    .clk(clk), .nReset(nReset), .clear_i(clr), .load_i(ld), .load_value_i(lv[3:0]),
    .en_i(en), .up_i(up), .value_o(v3), .wrap_o(w3), .at_max_o(mx3),
    .at_zero_o(z3), .load_err_o(le3));

  typedef struct {
    logic        clr, ld;
    logic [19:0] lv;
    logic        en, up;
    logic [19:0] ev;
    logic        ew, ele, emax, ezero;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int n);
    logic [19:0] r;
    int k;
    k = n;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(k % 10);
      k = k / 10;
    end
    return r;
  endfunction

  task automatic apply(input logic c, input logic l, input logic [19:0] val,
                       input logic e, input logic u);
    clr = c; ld = l; lv = val; en = e; up = u;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    apply(1'b0, 1'b0, 20'h0, 1'b0, 1'b0);
    nReset = 1'b1;
  endtask

  initial begin
    nReset = 1'b0; clr = 0; ld = 0; lv = '0; en = 0; up = 0;

    //            clr ld  lv          en up  ev          w  le max zero
    tbl[0]  = '{1'b0, 1'b1, 20'h99998, 1'b0, 1'b0, 20'h99998, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b1, 20'h99999, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b1, 20'h00000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 20'h00000, 1'b0, 1'b1, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 20'h01000, 1'b0, 1'b0, 20'h01000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 20'h00999, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 20'h00001, 1'b0, 1'b0, 20'h00001, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 20'h99999, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 20'h1A3F2, 1'b0, 1'b0, 20'h19392, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 20'h19392, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 20'h1A3F2, 1'b0, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 20'h00345, 1'b1, 1'b1, 20'h00345, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b1, 20'h00346, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 20'h00000, 1'b1, 1'b0, 20'h00345, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 20'h00000, 1'b1, 1'b1, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 20'hFFFFF, 1'b0, 1'b0, 20'h99999, 1'b0, 1'b1, 1'b1, 1'b0};

    do_reset();
    chk("rst value", v0, 20'h0);
    chk("rst wrap", 20'(w0), 20'h0);
    chk("rst load_err", 20'(le0), 20'h0);
    chk("rst at_zero", 20'(z0), 20'h1);
    chk("rst at_max", 20'(mx0), 20'h0);

    for (int i = 1; i <= 12; i++) begin
      apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b1);
      chk($sformatf("count%0d value", i), v0, to_bcd(i));
      chk($sformatf("count%0d wrap", i), 20'(w0), 20'h0);
    end

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].up);
      chk($sformatf("vec%0d value", i), v0, tbl[i].ev);
      chk($sformatf("vec%0d wrap", i), 20'(w0), 20'(tbl[i].ew));
      chk($sformatf("vec%0d load_err", i), 20'(le0), 20'(tbl[i].ele));
      chk($sformatf("vec%0d at_max", i), 20'(mx0), 20'(tbl[i].emax));
      chk($sformatf("vec%0d at_zero", i), 20'(z0), 20'(tbl[i].ezero));
    end

    // Saturating variant holds at both limits and flags every enabled cycle there.
    do_reset();
    apply(1'b0, 1'b1, 20'h99998, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b1);
    chk("sat up1 value", v1, 20'h99999);
    chk("sat up1 wrap", 20'(w1), 20'h0);
    chk("sat up1 at_max", 20'(mx1), 20'h1);
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b1);
      chk($sformatf("sat hold%0d value", i), v1, 20'h99999);
      chk($sformatf("sat hold%0d wrap", i), 20'(w1), 20'h1);
    end
    apply(1'b0, 1'b1, 20'h00000, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b0);
    chk("sat dn value", v1, 20'h0);
    chk("sat dn wrap", 20'(w1), 20'h1);
    chk("sat dn at_zero", 20'(z1), 20'h1);

    // Reduced upper limit 59.
    do_reset();
    apply(1'b0, 1'b1, 20'h00058, 1'b0, 1'b0);
    chk("m59 load value", v2, 20'h00058);
    chk("m59 load at_max", 20'(mx2), 20'h0);
    apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b1);
    chk("m59 up value", v2, 20'h00059);
    chk("m59 up at_max", 20'(mx2), 20'h1);
    chk("m59 up wrap", 20'(w2), 20'h0);
    apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b1);
    chk("m59 wrap value", v2, 20'h0);
    chk("m59 wrap wrap", 20'(w2), 20'h1);
    apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b0);
    chk("m59 dnwrap value", v2, 20'h00059);
    chk("m59 dnwrap wrap", 20'(w2), 20'h1);
    apply(1'b0, 1'b1, 20'h00077, 1'b0, 1'b0);
    chk("m59 ld77 value", v2, 20'h00059);
    chk("m59 ld77 load_err", 20'(le2), 20'h1);
    apply(1'b0, 1'b1, 20'h00050, 1'b0, 1'b0);
    chk("m59 ld50 value", v2, 20'h00050);
    chk("m59 ld50 load_err", 20'(le2), 20'h0);
    apply(1'b0, 1'b1, 20'h00060, 1'b0, 1'b0);
    chk("m59 ld60 value", v2, 20'h00059);
    chk("m59 ld60 load_err", 20'(le2), 20'h1);

    // Single-digit variant.
    do_reset();
    apply(1'b0, 1'b1, 20'h00008, 1'b0, 1'b0);
    chk("d1 load value", 20'(v3), 20'h8);
    apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b1);
    chk("d1 up value", 20'(v3), 20'h9);
    chk("d1 up at_max", 20'(mx3), 20'h1);
    apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b1);
    chk("d1 wrap value", 20'(v3), 20'h0);
    chk("d1 wrap wrap", 20'(w3), 20'h1);
    apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b0);
    chk("d1 dnwrap value", 20'(v3), 20'h9);
    chk("d1 dnwrap wrap", 20'(w3), 20'h1);
    apply(1'b0, 1'b1, 20'h0000C, 1'b0, 1'b0);
    chk("d1 ldC value", 20'(v3), 20'h9);
    chk("d1 ldC load_err", 20'(le3), 20'h1);

    // Reset together with an illegal load mid-count.
    do_reset();
    apply(1'b0, 1'b1, 20'h00344, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 20'h0, 1'b1, 1'b1);
    chk("rstld pre value", v0, 20'h00345);
    nReset = 1'b0;
    apply(1'b0, 1'b1, 20'h1A3F2, 1'b1, 1'b1);
    nReset = 1'b1;
    chk("rstld value", v0, 20'h0);
    chk("rstld at_zero", 20'(z0), 20'h1);
    chk("rstld load_err", 20'(le0), 20'h0);
    chk("rstld wrap", 20'(w0), 20'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised N-digit packed-BCD up/down counter with enable, parallel load, synchronous clear, and selectable wrap or saturate mode. It is the general counting primitive for the display and timing paths: event counters, stopwatch digits and seven-segment feed. Each digit is 4 bits, least-significant digit in bits [3:0]. All outputs are registered.

Parameters:
DIGITS, 5, number of BCD digits; value width is 4*DIGITS; legal range 1..8
SATURATE, 0, 0 = wrap at the limits; 1 = hold at the limits
MAX_BCD, all digits 9 (DIGITS×4'h9), upper limit in packed BCD; every digit must be ≤9

Ports:
clk  input  1  clock; all state updates on the rising edge
nReset  input  1  synchronous, active-low reset
clear  input  1  synchronous clear to zero
load  input  1  parallel load strobe
load_value  input  4*DIGITS  packed-BCD value to load
en  input  1  count enable; one step per cycle while high
up  input  1  direction: 1 = increment, 0 = decrement
value  output  4*DIGITS  current count, packed BCD; always valid BCD
wrap  output  1  one-cycle pulse: the counter wrapped (SATURATE=0) or hit a limit (SATURATE=1)
at_max  output  1  high while value == MAX_BCD
at_zero  output  1  high while value == 0
load_err  output  1  one-cycle pulse: load_value was illegal and was corrected

Behaviour:
- Clock and reset: clk; nReset is synchronous, active-low. Reset values: value = 0, wrap = 0, load_err = 0, at_zero = 1, at_max = 0.
- Priority, evaluated at each rising edge: nReset > clear > load > en. With none of these active, value holds and both pulses are 0.
- clear: value ← 0. wrap and load_err are 0 that cycle.
- load: each digit of load_value that is >9 is replaced by 9.
  - If the corrected value is > MAX_BCD, value ← MAX_BCD.
  - load_err pulses for 1 cycle if either correction occurred.
  - wrap is 0 on a load cycle.
  - en is ignored on a load cycle.
- Count up (en=1, up=1):
  - Digit-wise BCD increment with ripple carry: a digit at 9 becomes 0 and carries into the next digit.
  - A carry out of a digit never leaves a non-BCD code in any cycle.
  - At MAX_BCD with SATURATE=0: value ← 0 and wrap=1.
  - At MAX_BCD with SATURATE=1: value holds and wrap=1.
- Count down (en=1, up=0):
  - Digit-wise BCD decrement with borrow: a digit at 0 becomes 9 and borrows from the next digit.
  - At 0 with SATURATE=0: value ← MAX_BCD and wrap=1.
  - At 0 with SATURATE=1: value holds and wrap=1.
- Non-all-9s MAX_BCD (for example 0x00059):
  - Up-wrap occurs when value == MAX_BCD, not at the digit rollover.
  - Values above MAX_BCD are unreachable.
- Latency:
  - value reflects an operation one cycle after the edge that samples it.
  - wrap and load_err are registered and coincide with the updated value.
  - at_max and at_zero are registered and consistent with value in the same cycle.
- Direction change takes effect on the next enabled edge; no dead cycle.
- Reset mid-count overrides everything, including a simultaneous load or clear.
- Simultaneous clear and load: clear wins; load_err = 0.
- DIGITS=1 must work; the carry chain degenerates to a single digit.

Test Plan:
- Reset then en=1, up=1 for 12 cycles → value 0x00000 → 0x00009 → 0x00010 → 0x00011 → 0x00012; wrap never asserted.
- load 0x99998, then en=1, up=1 → 0x99999, then 0x00000 with wrap=1 for exactly 1 cycle. Repeat with SATURATE=1 → value holds at 0x99999; wrap=1 on each enabled cycle at the limit.
- load 0x01000, then en=1, up=0 → 0x00999; decrement continues down to 0x00000, next step gives 0x99999 with wrap=1.
- load_value 0x1A3F2 → value 0x19392; load_err=1 for 1 cycle. Same value with load and clear both high → 0x00000; load_err=0.
- MAX_BCD=0x00059, count up from 0x00058 → 0x00059 (at_max=1), then 0x00000 with wrap=1. load 0x00077 → 0x00059 with load_err=1.
- Count to 0x00345, assert nReset=0 together with load=1 for 1 cycle → value 0x00000, at_zero=1, load_err=0.
